// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative N x N multiply (shift-add) and N / N divide
// (restoring) sharing one 2N-bit working accumulator. Results land in
// hi/lo only on the FIX edge, so hi/lo keep the previous result while an
// operation runs.
// Optional feature macro: MDU_SIGNED_EN (signed MULT/DIV via magnitude
// conversion and result negation). Without it every op is unsigned.
module mul_div_unit #(
    parameter int unsigned N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] inA,
    input  logic [N-1:0] inB,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         div_by_zero
);

    localparam int unsigned CW = $clog2(N);
    localparam int unsigned AW = 2 * N;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  a_orig_q, a_orig_d;
    logic          is_div_q, is_div_d;
    logic          b_zero_q, b_zero_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dbz_q, dbz_d;
    logic [N-1:0]  hi_q, hi_d;
    logic [N-1:0]  lo_q, lo_d;

    logic [N-1:0]  a_mag_c;
    logic [N-1:0]  b_mag_c;
    logic [N:0]    mul_sum_c;
    logic          div_ge_c;
    logic [N-1:0]  div_sub_c;
    logic [AW-1:0] prod_c;
    logic [N-1:0]  quo_c;
    logic [N-1:0]  rem_c;

`ifdef MDU_SIGNED_EN
    logic          neg_q, neg_d;
    logic          dsign_q, dsign_d;
    logic          a_neg_c;
    logic          b_neg_c;

    // Operand sign detection and magnitude conversion for signed ops
    always_comb begin
        a_neg_c = op[0] & inA[N-1];
        b_neg_c = op[0] & inB[N-1];
        a_mag_c = a_neg_c ? N'(-inA) : inA;
        b_mag_c = b_neg_c ? N'(-inB) : inB;
    end

    // Final sign correction of product, quotient and remainder
    always_comb begin
        prod_c = neg_q ? AW'(-acc_q) : acc_q;
        quo_c  = neg_q ? N'(-acc_q[N-1:0]) : acc_q[N-1:0];
        rem_c  = dsign_q ? N'(-acc_q[AW-1:N]) : acc_q[AW-1:N];
    end
`else
    // op[0] selects signedness, which this build does not implement
    logic op_sign_unused_c;
    assign op_sign_unused_c = op[0];

    // Unsigned build: operands and results pass straight through
    always_comb begin
        a_mag_c = inA;
        b_mag_c = inB;
        prod_c  = acc_q;
        quo_c   = acc_q[N-1:0];
        rem_c   = acc_q[AW-1:N];
    end
`endif

    // One iteration of shift-add (multiply) and restoring subtract (divide)
    always_comb begin
        mul_sum_c = {1'b0, acc_q[AW-1:N]} + (acc_q[0] ? {1'b0, b_q} : {(N+1){1'b0}});
        div_ge_c  = acc_q[AW-1:N-1] >= {1'b0, b_q};
        div_sub_c = acc_q[AW-2:N-1] - b_q;
    end

    // Next-state and register updates for IDLE -> RUN -> FIX sequencing
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        a_orig_d = a_orig_q;
        is_div_d = is_div_q;
        b_zero_d = b_zero_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef MDU_SIGNED_EN
        neg_d    = neg_q;
        dsign_d  = dsign_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    acc_d    = {{N{1'b0}}, a_mag_c};
                    b_d      = b_mag_c;
                    a_orig_d = inA;
                    is_div_d = op[1];
                    b_zero_d = (inB == '0);
                    dbz_d    = 1'b0;
                    busy_d   = 1'b1;
`ifdef MDU_SIGNED_EN
                    neg_d    = a_neg_c ^ b_neg_c;
                    dsign_d  = a_neg_c;
`endif
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    acc_d = div_ge_c ? {div_sub_c, acc_q[N-2:0], 1'b1}
                                     : {acc_q[AW-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum_c, acc_q[N-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (is_div_q) begin
                    if (b_zero_q) begin
                        hi_d  = a_orig_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        hi_d = rem_c;
                        lo_d = quo_c;
                    end
                end else begin
                    hi_d = prod_c[AW-1:N];
                    lo_d = prod_c[N-1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            a_orig_q <= '0;
            is_div_q <= 1'b0;
            b_zero_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MDU_SIGNED_EN
            neg_q    <= 1'b0;
            dsign_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            a_orig_q <= a_orig_d;
            is_div_q <= is_div_d;
            b_zero_q <= b_zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef MDU_SIGNED_EN
            neg_q    <= neg_d;
            dsign_q  <= dsign_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit (N=32): an arithmetic reference model with a
// per-cycle output comparison, plus directed vectors with literal results.
module tb_mul_div_unit;

    localparam int unsigned N = 32;
`ifdef MDU_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [N-1:0]  inA;
    logic [N-1:0]  inB;
    logic          busy;
    logic          done;
    logic [N-1:0]  hi;
    logic [N-1:0]  lo;
    logic          div_by_zero;

    int n_pass;
    int n_total;

    mul_div_unit #(.N(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .inA         (inA),
        .inB         (inB),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference result {div_by_zero, hi, lo} from plain arithmetic
    function automatic logic [64:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        logic        sgn;
        longint      sa, sb, q, r;
        logic [63:0] p;
        sgn = SIGNED_EN && o[0];
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        if (!o[1]) begin
            if (sgn) p = 64'(sa * sb);
            else     p = {32'b0, a} * {32'b0, b};
            return {1'b0, p};
        end
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (sgn) begin
            q = sa / sb;
            r = sa % sb;
            return {1'b0, r[31:0], q[31:0]};
        end
        return {1'b0, a % b, a / b};
    endfunction

    // Transaction-level model: accept when idle, results appear N+1 edges later
    logic        m_busy, m_done, m_dbz;
    logic [31:0] m_hi, m_lo;
    logic [64:0] m_pend;
    int          m_left;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
            m_hi <= '0; m_lo <= '0; m_pend <= '0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy && start) begin
                m_busy <= 1'b1;
                m_dbz  <= 1'b0;
                m_left <= N;
                m_pend <= ref_result(op, inA, inB);
            end else if (m_busy) begin
                if (m_left == 0) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    {m_dbz, m_hi, m_lo} <= m_pend;
                end else begin
                    m_left <= m_left - 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clock) begin
        check("cycle_outputs", {13'b0, busy, done, div_by_zero, hi, lo},
              {13'b0, m_busy, m_done, m_dbz, m_hi, m_lo});
    end

    // Issue one op (called 2 time units after an edge) and wait for done
    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input logic edbz, input bit inject, input logic [31:0] ph,
                          input logic [31:0] pl);
        int lat;
        int bcnt;
        start = 1'b1; op = o; inA = a; inB = b;
        @(posedge clock); #2;
        start = 1'b0; op = ~o; inA = $urandom; inB = $urandom;
        check({nm, "_accept_busy_dbz"}, {78'b0, busy, div_by_zero}, 80'b10);
        bcnt = busy ? 1 : 0;
        lat  = 0;
        for (int k = 1; k <= 60; k++) begin
            if (inject && (k == 5 || k == 20)) begin
                start = 1'b1; op = 2'b00; inA = 32'd7; inB = 32'd7;
            end
            @(posedge clock); #2;
            start = 1'b0;
            if (inject && k == 25) check({nm, "_hold_hilo"}, {16'b0, hi, lo}, {16'b0, ph, pl});
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) $display("FAIL %s_timeout: got no done, required done within 60 edges", nm);
        check({nm, "_latency"}, 80'(lat), 80'd33);
        check({nm, "_busy_cycles"}, 80'(bcnt), 80'd33);
        check({nm, "_result"}, {15'b0, div_by_zero, hi, lo}, {15'b0, edbz, eh, el});
    endtask

    initial begin
        int dcnt;
        n_pass = 0; n_total = 0;
        reset = 1'b1; start = 1'b0; op = 2'b00; inA = '0; inB = '0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        check("reset_state", {13'b0, busy, done, div_by_zero, hi, lo}, 80'b0);
        @(posedge clock); #2;

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
               1'b0, 1'b0, '0, '0);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, '0, '0);
        run_op("divu_by_zero", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, '0, '0);
        run_op("multu_clears_dbz", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0, '0, '0);
`ifdef MDU_SIGNED_EN
        run_op("mult_m3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
               1'b0, 1'b0, '0, '0);
        run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
               1'b0, 1'b0, '0, '0);
        run_op("div_minneg_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000,
               1'b0, 1'b0, '0, '0);
`else
        run_op("mult_m3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB,
               1'b0, 1'b0, '0, '0);
        run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC,
               1'b0, 1'b0, '0, '0);
        run_op("div_minneg_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,
               1'b0, 1'b0, '0, '0);
`endif
        run_op("div_by_zero_neg", 2'b11, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF,
               1'b1, 1'b0, '0, '0);
        // Ignored start pulses mid-run; previous result must persist
        run_op("handshake_ignore", 2'b10, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b0, 1'b1,
               32'hFFFF_FFF7, 32'hFFFF_FFFF);
        // Issued in the done cycle of the previous op
        run_op("back_to_back", 2'b00, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780,
               1'b0, 1'b0, '0, '0);

        // Reset in the middle of an operation
        start = 1'b1; op = 2'b10; inA = 32'hFFFF_FFFF; inB = 32'd3;
        @(posedge clock); #2;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2 reset = 1'b0;
        #1 check("midop_reset", {13'b0, busy, done, div_by_zero, hi, lo}, 80'b0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        dcnt = 0;
        repeat (40) begin
            @(posedge clock); #2;
            if (done) dcnt++;
        end
        check("no_done_after_reset", 80'(dcnt), 80'd0);
        run_op("divu_9_3", 2'b10, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 1'b0, '0, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multi-cycle multiply/divide unit, parametrised in operand width. It computes N×N→2N products and N/N quotient/remainder into HI/LO result registers. It extends the single-cycle combinational ALU with sequential operations that run under a start/busy/done handshake. It sits beside the ALU in the execute stage; the control FSM issues `start` and stalls on `busy`.

## Interface

**Parameters**
- `N`, default 32: operand width. N ≥ 4. Iteration counter width is clog2(N).

**Ports**
- `clock`, in, 1: all state updates on posedge.
- `reset`, in, 1: asynchronous, active-low.
- `start`, in, 1: request an operation. Sampled only when `busy`=0.
- `op`, in, 2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `inA`, `inB`, in, N each: multiplicand/multiplier, or dividend/divisor. Sampled only at the accepting edge.
- `busy`, out, 1: operation in progress.
- `done`, out, 1: one-cycle pulse when `hi`/`lo` are updated.
- `hi`, `lo`, out, N each:
  - Multiply: product[2N-1:N] and product[N-1:0].
  - Divide: remainder and quotient.
- `div_by_zero`, out, 1: last divide had `inB`=0.

## Operation

**States:** IDLE, RUN, FIX.
- **IDLE**, `start`=1 → RUN.
  - Latch operands. For signed ops with `MDU_SIGNED_EN`, latch magnitudes plus a negate-result flag and a dividend-sign flag.
  - Clear the iteration counter. Clear `div_by_zero`.
  - `busy`=1.
- **RUN** performs one iteration per edge.
  - Multiply: shift-add on a 2N-bit accumulator.
  - Divide: restoring shift-subtract.
  - After the N-th iteration → FIX.
- **FIX** corrects signs and writes `hi`/`lo`.
  - Sets `done`=1 and `busy`=0, then → IDLE.

**Signed results**
- Product is negated (2N-bit two's complement) when operand signs differ.
- Quotient is negated when signs differ. Remainder takes the dividend's sign.
- Most-negative / −1 gives `lo` = 2^(N-1) (wraps to the most-negative value) and `hi` = 0. No trap.

**Divide by zero**
- Sets `div_by_zero`=1, `hi`=`inA` (original, unconverted), `lo`=all ones, for signed or unsigned ops.
- Latency is unchanged.
- `div_by_zero` holds until the next accepted `start`. Multiplies clear it.

**Handshake and register behaviour**
- `start` while `busy`=1 is ignored. No queueing.
- `hi`/`lo` hold the previous result throughout RUN. They change only at the FIX edge, using separate working registers.
- `inA`/`inB`/`op` may change freely after the accepting edge.

**Reset**
- `reset`=0 at any time, including mid-operation, abandons the operation. No `done` pulse is produced.
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_by_zero`=0, counter 0.

## Timing

- Edge e0 accepts `start`. Edges e1..eN run the N iterations. Edge eN+1 is FIX.
- `done` is high for exactly the cycle after eN+1. Total latency is N+1 edges (33 for N=32), identical for all ops.
- `busy` is high from e0 until eN+1, and low in the `done` cycle.
- A new `start` in the `done` cycle is accepted at eN+2. Back-to-back throughput is one op per N+2 cycles.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration

- `MDU_SIGNED_EN` defined: MULT and DIV perform signed operation as above.
- Undefined:
  - `op[0]` is ignored, and all ops are unsigned.
  - Sign logic and negation adders are not compiled in.
  - FIX still occupies one cycle, so latency is unchanged.

## Test plan

All scenarios use N=32.

- **MULTU:** 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. `done` pulses 33 edges after the accepting edge; `busy` is high for exactly 33 cycles.
- **Signed (with `MDU_SIGNED_EN`):**
  - MULT −3 × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
  - DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Unsigned divide:**
  - DIVU 100 / 7 → `lo`=14, `hi`=2, `div_by_zero`=0.
  - DIVU 5 / 0 → `hi`=5, `lo`=0xFFFFFFFF, `div_by_zero`=1 after the same 33-edge latency. The flag clears on the next accepted `start`.
- **Handshake:**
  - `start` pulses at cycles 5 and 20 of a running op are ignored; `hi`/`lo` keep old values until `done`.
  - `start` held high in the `done` cycle launches a second op that completes 33 edges later.
- **Reset mid-operation:** `reset` low at iteration 10 → immediately `busy`=0, `hi`=`lo`=0, no `done` pulse. After release, DIVU 9/3 → `lo`=3, `hi`=0.
- **Without `MDU_SIGNED_EN`:** MULT −3 × 7 → `hi`=0x00000006, `lo`=0xFFFFFFEB (unsigned result).
